// File: rtl/prog_instr_mem.sv
// Parametrised instruction store with a handshaked burst program loader
// and a registered, stall-aware fetch port.
module prog_instr_mem #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_start,
  input  logic [ADDR_W-1:0] load_base,
  input  logic [ADDR_W:0]   load_len,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_ready,
  input  logic              load_abort,
  output logic              load_busy,
  output logic              load_done,
  output logic              load_err,
  output logic [ADDR_W:0]   load_count,
  input  logic              fetch_en,
  input  logic [ADDR_W-1:0] program_counter,
  output logic [DATA_W-1:0] data_out,
  output logic              fetch_valid,
  output logic              fetch_stall
);

  typedef enum logic {IDLE, LOAD} state_e;

  localparam logic [ADDR_W+1:0] DEPTH_X = (ADDR_W+2)'(DEPTH);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [ADDR_W:0]     len_q, len_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   data_out_q, data_out_d;
  logic                fetch_valid_q, fetch_valid_d;

  logic [DATA_W-1:0]   mem [DEPTH];
  logic                mem_we;
  logic                beat;
  logic [ADDR_W+1:0]   req_end;
  logic [ADDR_W:0]     count_inc;

  // Sum widened by two bits so base+len can never wrap past DEPTH.
  assign req_end   = {2'b00, load_base} + {1'b0, load_len};
  assign count_inc = count_q + (ADDR_W+1)'(1);
  assign beat      = (state_q == LOAD) && load_valid;

  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    state_d       = state_q;
    ptr_d         = ptr_q;
    len_d         = len_q;
    count_d       = count_q;
    done_d        = 1'b0;
    err_d         = 1'b0;
    data_out_d    = data_out_q;
    fetch_valid_d = 1'b0;
    mem_we        = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (fetch_en) begin
          fetch_valid_d = 1'b1;
          data_out_d    = ({2'b00, program_counter} < DEPTH_X)
                          ? mem[program_counter] : '0;
        end
        if (load_start) begin
          if (load_len == '0) begin
            done_d  = 1'b1;
            count_d = '0;
          end else if (({2'b00, load_base} >= DEPTH_X) || (req_end > DEPTH_X)) begin
            err_d = 1'b1;
          end else begin
            state_d = LOAD;
            ptr_d   = load_base;
            len_d   = load_len;
            count_d = '0;
          end
        end
      end
      LOAD: begin
        // Abort wins over a beat presented in the same cycle.
        if (load_abort) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else if (beat) begin
          mem_we  = 1'b1;
          ptr_d   = ptr_q + ADDR_W'(1);
          count_d = count_inc;
          if (count_inc == len_q) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      ptr_q         <= '0;
      len_q         <= '0;
      count_q       <= '0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      data_out_q    <= '0;
      fetch_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      len_q         <= len_d;
      count_q       <= count_d;
      done_q        <= done_d;
      err_q         <= err_d;
      data_out_q    <= data_out_d;
      fetch_valid_q <= fetch_valid_d;
    end
  end

  // NOTE: the array has no reset so it maps to RAM and keeps contents across rst_n.
  always_ff @(posedge clk) begin
    if (mem_we) mem[ptr_q] <= load_data;
  end

  assign load_ready  = (state_q == LOAD);
  assign load_busy   = (state_q == LOAD);
  assign fetch_stall = (state_q == LOAD);
  assign load_done   = done_q;
  assign load_err    = err_q;
  assign load_count  = count_q;
  assign data_out    = data_out_q;
  assign fetch_valid = fetch_valid_q;

endmodule

// File: tb/tb_prog_instr_mem.sv
// Directed self-checking bench for prog_instr_mem: burst load, gaps,
// range rejection, abort, fetch stalling and reset during a load.
module tb_prog_instr_mem;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 10;
  localparam int DEPTH  = 1024;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              load_start;
  logic [ADDR_W-1:0] load_base;
  logic [ADDR_W:0]   load_len;
  logic              load_valid;
  logic [DATA_W-1:0] load_data;
  logic              load_ready;
  logic              load_abort;
  logic              load_busy;
  logic              load_done;
  logic              load_err;
  logic [ADDR_W:0]   load_count;
  logic              fetch_en;
  logic [ADDR_W-1:0] program_counter;
  logic [DATA_W-1:0] data_out;
  logic              fetch_valid;
  logic              fetch_stall;

  int n_cmp = 0;
  int n_bad = 0;

  prog_instr_mem #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .load_start(load_start), .load_base(load_base), .load_len(load_len),
    .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
    .load_abort(load_abort), .load_busy(load_busy), .load_done(load_done),
    .load_err(load_err), .load_count(load_count),
    .fetch_en(fetch_en), .program_counter(program_counter),
    .data_out(data_out), .fetch_valid(fetch_valid), .fetch_stall(fetch_stall)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outs(input string tag);
    check({tag, " busy"},  32'(load_busy),   0);
    check({tag, " ready"}, 32'(load_ready),  0);
    check({tag, " stall"}, 32'(fetch_stall), 0);
    check({tag, " done"},  32'(load_done),   0);
    check({tag, " err"},   32'(load_err),    0);
    check({tag, " fv"},    32'(fetch_valid), 0);
  endtask

  task automatic start(input logic [ADDR_W-1:0] base, input logic [ADDR_W:0] len);
    load_start = 1'b1; load_base = base; load_len = len;
    step();
    load_start = 1'b0;
  endtask

  task automatic beat(input logic [DATA_W-1:0] d);
    load_valid = 1'b1; load_data = d;
    step();
    load_valid = 1'b0;
  endtask

  task automatic fetch(input string tag, input logic [ADDR_W-1:0] pc, input logic [DATA_W-1:0] exp);
    fetch_en = 1'b1; program_counter = pc;
    step();
    fetch_en = 1'b0;
    check({tag, " fv"},   32'(fetch_valid), 1);
    check({tag, " data"}, 32'(data_out),    32'(exp));
  endtask

  initial begin
    rst_n = 1'b0; load_start = 0; load_base = '0; load_len = '0;
    load_valid = 0; load_data = '0; load_abort = 0; fetch_en = 0; program_counter = '0;

    // Reset values
    #12;
    check_idle_outs("rst");
    check("rst data_out", 32'(data_out),   0);
    check("rst count",    32'(load_count), 0);
    rst_n = 1'b1;
    step();
    check_idle_outs("post_rst");

    // Burst load of three words
    start(10'd0, 11'd3);
    check("burst busy",  32'(load_busy),   1);
    check("burst ready", 32'(load_ready),  1);
    check("burst stall", 32'(fetch_stall), 1);
    beat(16'h1234);
    load_valid = 1; load_data = 16'h5678; step();
    check("burst mid done", 32'(load_done), 0);
    load_data = 16'hABCD; step(); load_valid = 0;
    check("burst done",  32'(load_done),  1);
    check("burst busy0", 32'(load_busy),  0);
    check("burst count", 32'(load_count), 3);
    step();
    check("burst done1", 32'(load_done), 0);
    fetch("f0", 10'd0, 16'h1234);
    fetch("f1", 10'd1, 16'h5678);
    fetch("f2", 10'd2, 16'hABCD);
    step();
    check("idle fv",   32'(fetch_valid), 0);
    check("idle hold", 32'(data_out),    32'hABCD);

    // Single word with gaps in load_valid
    start(10'd100, 11'd1);
    step();
    check("gap done0", 32'(load_done), 0);
    step();
    check("gap busy",  32'(load_busy), 1);
    beat(16'hFFFF);
    check("gap done",  32'(load_done),  1);
    check("gap count", 32'(load_count), 1);
    step();
    check("gap done1", 32'(load_done), 0);
    fetch("f100", 10'd100, 16'hFFFF);
    fetch("f0b",  10'd0,   16'h1234);

    // Out-of-range and zero-length starts
    start(10'd1020, 11'd5);
    check("oor err",   32'(load_err),   1);
    check("oor busy",  32'(load_busy),  0);
    check("oor count", 32'(load_count), 1);
    step();
    check("oor err1",  32'(load_err),   0);
    start(10'd1020, 11'd0);
    check("zero done",  32'(load_done),  1);
    check("zero busy",  32'(load_busy),  0);
    check("zero count", 32'(load_count), 0);
    check("zero err",   32'(load_err),   0);
    step();

    // Boundary: last word in the array is loadable
    start(10'd1023, 11'd1);
    check("edge busy", 32'(load_busy), 1);
    beat(16'hBEEF);
    check("edge done", 32'(load_done), 1);
    fetch("f1023", 10'd1023, 16'hBEEF);

    // Known value at 12 so the abort test can see it untouched
    start(10'd12, 11'd1);
    beat(16'h0C0C);
    step();

    // Abort with a concurrent valid beat
    start(10'd10, 11'd4);
    beat(16'h1111);
    beat(16'h2222);
    load_valid = 1; load_data = 16'h3333; load_abort = 1;
    step();
    load_valid = 0; load_abort = 0;
    check("abort err",   32'(load_err),   1);
    check("abort done",  32'(load_done),  0);
    check("abort busy",  32'(load_busy),  0);
    check("abort count", 32'(load_count), 2);
    step();
    check("abort err1",  32'(load_err),   0);
    fetch("f10", 10'd10, 16'h1111);
    fetch("f11", 10'd11, 16'h2222);
    fetch("f12", 10'd12, 16'h0C0C);

    // Fetch held high across a load; same-cycle start and fetch
    fetch_en = 1; program_counter = 10'd10;
    load_start = 1; load_base = 10'd200; load_len = 11'd2;
    step();
    load_start = 0;
    check("sc fv",   32'(fetch_valid), 1);
    check("sc data", 32'(data_out),    32'h1111);
    check("sc busy", 32'(load_busy),   1);
    program_counter = 10'd0;
    beat(16'hA0A0);
    check("stall fv",    32'(fetch_valid), 0);
    check("stall st",    32'(fetch_stall), 1);
    check("stall hold",  32'(data_out),    32'h1111);
    beat(16'hB0B0);
    check("stall done",  32'(load_done),   1);
    check("stall fv2",   32'(fetch_valid), 0);
    check("stall hold2", 32'(data_out),    32'h1111);
    check("stall st0",   32'(fetch_stall), 0);
    step();
    check("resume fv",   32'(fetch_valid), 1);
    check("resume data", 32'(data_out),    32'h1234);
    fetch_en = 0;
    fetch("f201", 10'd201, 16'hB0B0);

    // Reset in the middle of a load
    start(10'd300, 11'd3);
    beat(16'h3001);
    rst_n = 1'b0;
    #1;
    check_idle_outs("mid_rst");
    check("mid_rst count", 32'(load_count), 0);
    check("mid_rst data",  32'(data_out),   0);
    #1 rst_n = 1'b1;
    step();
    check_idle_outs("after_rst");
    start(10'd301, 11'd1);
    check("rst restart busy", 32'(load_busy), 1);
    beat(16'h3002);
    check("rst restart done", 32'(load_done), 1);
    fetch("f300", 10'd300, 16'h3001);
    fetch("f301", 10'd301, 16'h3002);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
